alu_pipe: RTL and testbench

//  - Parametrised, 2-stage pipelined successor to the single-cycle 16-bit ALU.
//  - Adds ADD/SUB/XOR/NAND/SLL/SRA/ROR, valid/ready handshakes on input and output, and a registered Z/V/N flag file.
//  - Sits between decode/issue and writeback; flags feed branch resolution.

---
 rtl/alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and a registered Z/V/N flag file.
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRA  = 3'd5,
    OP_ROR  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  if (SHW != $clog2(WIDTH)) begin : g_bad_shw
    $error("alu_pipe: SHW must equal clog2(WIDTH)");
  end

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             s2_legal_q, s2_legal_d;
  logic             s2_arith_q, s2_arith_d;

  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic             flag_n_q, flag_n_d;

  logic             s1_adv, s2_adv, out_xfer;
  logic [WIDTH-1:0] sum, diff, alu_r;
  logic             alu_ovf, alu_err;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     amt_l;

  // Stage-2 combinational datapath, fed from the stage-1 registers.
  always_comb begin
    amt     = s1_b_q[SHW-1:0];
    amt_l   = (SHW+1)'(WIDTH) - {1'b0, amt};
    sum     = s1_a_q + s1_b_q;
    diff    = s1_a_q + ~s1_b_q + WIDTH'(1);
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_r   = sum;
        alu_ovf = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        alu_r   = diff;
        alu_ovf = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
      end
      OP_XOR:  alu_r = s1_a_q ^ s1_b_q;
      OP_NAND: alu_r = ~(s1_a_q & s1_b_q);
      OP_SLL:  alu_r = s1_a_q << amt;
      OP_SRA:  alu_r = $signed(s1_a_q) >>> amt;
      // amt_l == WIDTH when amt == 0, so the left half shifts out completely.
      OP_ROR:  alu_r = (s1_a_q >> amt) | (s1_a_q << amt_l);
      default: alu_r = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a: positive a can only overflow upward.
    if (alu_ovf) begin
      alu_r = s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    alu_err = alu_ovf || (s1_op_q == OP_ILL);
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_xfer = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    err_d      = err_q;
    s2_legal_d = s2_legal_q;
    s2_arith_d = s2_arith_q;
    flag_z_d   = flag_z_q;
    flag_v_d   = flag_v_q;
    flag_n_d   = flag_n_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_e'(op);
        s1_a_d  = a;
        s1_b_d  = b;
      end
    end

    // An empty stage 1 advancing leaves the old result in place behind out_valid=0.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = alu_r;
        err_d      = alu_err;
        s2_legal_d = (s1_op_q != OP_ILL);
        s2_arith_d = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB);
      end
    end

    if (out_xfer) begin
      if (s2_legal_q) flag_z_d = (result_q == '0);
      if (s2_arith_q) begin
        flag_v_d = err_q;
        flag_n_d = result_q[MSB];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      s2_legal_q <= 1'b0;
      s2_arith_q <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      flag_n_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      err_q      <= err_d;
      s2_legal_q <= s2_legal_d;
      s2_arith_q <= s2_arith_d;
      flag_z_q   <= flag_z_d;
      flag_v_q   <= flag_v_d;
      flag_n_q   <= flag_n_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
  assign flag_n    = flag_n_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (WIDTH=16) against an in-bench reference model.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        in_ready, out_valid, err, flag_z, flag_v, flag_n;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] r;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  logic mz = 1'b0, mv = 1'b0, mn = 1'b0;
  logic armed = 1'b0;

  alu_pipe #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed integer arithmetic and bit-by-bit rotation.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int sx, sy, s, amt;
    logic [15:0] t;
    sx = $signed(x);
    sy = $signed(y);
    amt = int'(y[3:0]);
    e.op = o;
    e.r = 16'h0;
    e.e = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        s = (o == 3'd0) ? sx + sy : sx - sy;
        e.e = (s > 32767) || (s < -32768);
        e.r = 16'(s);
`ifdef ALU_SAT_EN
        if (s > 32767) e.r = 16'h7FFF;
        else if (s < -32768) e.r = 16'h8000;
`endif
      end
      3'd2: e.r = x ^ y;
      3'd3: e.r = ~(x & y);
      3'd4: e.r = x << amt;
      3'd5: e.r = 16'(sx >>> amt);
      3'd6: begin
        t = x;
        for (int i = 0; i < amt; i++) t = {t[0], t[15:1]};
        e.r = t;
      end
      default: e.e = 1'b1;
    endcase
    return e;
  endfunction

  // Compare process: evaluates the state that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mz = 1'b0; mv = 1'b0; mn = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      check("flag_z", flag_z, mz);
      check("flag_v", flag_v, mv);
      check("flag_n", flag_n, mn);
      check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_spurious", out_valid, 1'b0);
        end else begin
          check("result", result, exp_q[0].r);
          check("err", err, exp_q[0].e);
          if (out_ready) begin
            $display("xfer op=%0d result=0x%h err=%0d", exp_q[0].op, result, err);
            if (exp_q[0].op != 3'd7) mz = (exp_q[0].r == 16'h0);
            if (exp_q[0].op <= 3'd1) begin
              mv = exp_q[0].e;
              mn = exp_q[0].r[15];
            end
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    bit done = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1;
    end
    if (!seen) check("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic run_one(input string name, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic ee);
    int cyc;
    align();
    issue(o, x, y);
    wait_out(cyc);
    check({name, "_result"}, result, er);
    check({name, "_err"}, err, ee);
    $display("op %s a=0x%h b=0x%h -> result=0x%h err=%0d", name, x, y, result, err);
  endtask

  initial begin
    int cyc, x0;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0);
    check("rst_err", err, 1'b0);
    check("rst_flags", {flag_z, flag_v, flag_n}, 3'b000);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // ADD overflow with latency check
    align();
    issue(3'd0, 16'h7FFF, 16'h0001);
    wait_out(cyc);
    check("add_latency", cyc, 2);
`ifdef ALU_SAT_EN
    check("add_ovf_result", result, 16'h7FFF);
`else
    check("add_ovf_result", result, 16'h8000);
`endif
    check("add_ovf_err", err, 1'b1);
    @(negedge clk);
`ifdef ALU_SAT_EN
    check("add_ovf_flags", {flag_z, flag_v, flag_n}, 3'b010);
`else
    check("add_ovf_flags", {flag_z, flag_v, flag_n}, 3'b011);
`endif
    $display("op add_ovf result held flags zvn=%b%b%b", flag_z, flag_v, flag_n);

    // Back-to-back SUB, XOR, SRA
    align();
    fork
      begin
        issue(3'd1, 16'h0005, 16'h0005);
        issue(3'd2, 16'hF0F0, 16'hFFFF);
        issue(3'd5, 16'h8000, 16'h000F);
      end
      begin
        int c;
        wait_out(c);
        check("b2b_sub", result, 16'h0000);
        @(negedge clk);
        check("b2b_xor_valid", out_valid, 1'b1);
        check("b2b_xor", result, 16'h0F0F);
        check("b2b_sub_flags", {flag_z, flag_v, flag_n}, 3'b100);
        @(negedge clk);
        check("b2b_sra_valid", out_valid, 1'b1);
        check("b2b_sra", result, 16'hFFFF);
        @(negedge clk);
        check("b2b_end_flags", {flag_z, flag_v, flag_n}, 3'b000);
      end
    join
    $display("op b2b sub/xor/sra done");

    // Backpressure: two accepts fill the pipe, third waits
    align();
    out_ready = 1'b0;
    x0 = n_xfer;
    issue(3'd0, 16'h0001, 16'h0002);
    issue(3'd0, 16'h0010, 16'h0020);
    op = 3'd2; a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_hold", result, 16'h0003);
    end
    align();
    out_ready = 1'b1;
    issue(3'd2, 16'hAAAA, 16'h5555);
    repeat (4) @(negedge clk);
    check("bp_xfers", n_xfer - x0, 3);
    check("bp_idle", out_valid, 1'b0);
    check("bp_flags", {flag_z, flag_v, flag_n}, 3'b000);
    $display("op backpressure delivered %0d", n_xfer - x0);

    // Illegal op leaves flags alone even though result is zero
    run_one("illegal", 3'd7, 16'h1234, 16'h1234, 16'h0000, 1'b1);
    @(negedge clk);
    check("illegal_flags", {flag_z, flag_v, flag_n}, 3'b000);

    run_one("ror1", 3'd6, 16'h0001, 16'h0001, 16'h8000, 1'b0);
    run_one("ror4", 3'd6, 16'h1234, 16'h0014, 16'h4123, 1'b0);
    run_one("sll0", 3'd4, 16'hABCD, 16'h0010, 16'hABCD, 1'b0);
    run_one("sll4", 3'd4, 16'h0003, 16'h0004, 16'h0030, 1'b0);
    run_one("sra_pos", 3'd5, 16'h4000, 16'h0002, 16'h1000, 1'b0);
    run_one("nand", 3'd3, 16'hFF00, 16'h0FF0, 16'hF0FF, 1'b0);
`ifdef ALU_SAT_EN
    run_one("sub_ovf", 3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1);
    run_one("add_negovf", 3'd0, 16'h8000, 16'h8000, 16'h8000, 1'b1);
`else
    run_one("sub_ovf", 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    run_one("add_negovf", 3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1);
`endif
    run_one("add_small", 3'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    @(negedge clk);
    check("pre_rst_flags", {flag_z, flag_v, flag_n}, 3'b000);

    // Reset with two ops in flight
    align();
    issue(3'd0, 16'h7FFF, 16'h0001);
    issue(3'd1, 16'h0000, 16'h0000);
    rst = 1'b1;
    align();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_flags", {flag_z, flag_v, flag_n}, 3'b000);
    check("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    $display("op mid-flight reset applied");
    run_one("post_rst_xor", 3'd2, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d, required finish", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
